fetch_queue: RTL

Parametrised instruction prefetch queue between the synchronous program ROM and the decode stage of the pipelined RAT CPU, replacing the single-entry fetch latch and the delayed-PC stall mux. It owns the fetch PC, issues at most one ROM read per cycle, buffers up to DEPTH returned instruction/address pairs, and presents them to decode over a valid/ready handshake. A redirect input, driven by a taken branch, an interrupt vector or a return, flushes all buffered and in-flight words and restarts fetch at a new address.

---
 rtl/fetch_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between the synchronous program ROM and decode.
//
// Owns the fetch PC and issues at most one ROM read per cycle. Up to DEPTH returned
// {instr, addr} pairs are buffered and handed to decode over a valid/ready handshake.
// A redirect flushes buffered and in-flight words and restarts fetch at redirect_addr_i.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   defined   - when the buffer is empty, a returning ROM word is presented to decode
//               combinationally and, if accepted, never written into the buffer.
//   undefined - outputs always come from the registered buffer.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   redirect_valid_i flush and restart fetch at redirect_addr_i this cycle
//   redirect_addr_i  new fetch address
//   rom_addr_o       combinational address to the synchronous ROM
//   rom_instr_i      ROM data for the address issued in the previous cycle
//   out_valid_o      out_instr_o/out_addr_o hold a valid word
//   out_ready_i      decode accepts the word
//   out_instr_o      instruction at the queue head
//   out_addr_o       address of out_instr_o
//   count_o          buffered entries, excluding the in-flight word
module fetch_queue #(
  parameter int unsigned       INSTR_W    = 18,
  parameter int unsigned       ADDR_W     = 10,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         redirect_valid_i,
  input  logic [ADDR_W-1:0]            redirect_addr_i,
  output logic [ADDR_W-1:0]            rom_addr_o,
  input  logic [INSTR_W-1:0]           rom_instr_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [INSTR_W-1:0]           out_instr_o,
  output logic [ADDR_W-1:0]            out_addr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               pending_q, pending_d;
  logic [ADDR_W-1:0]  pending_addr_q, pending_addr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  addr_mem_q  [DEPTH];

  logic               bypass_active;
  logic               buf_valid;
  logic               pop;
  logic               pop_buf;
  logic               push;
  logic               issue;
  logic [CntW:0]      occupancy;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_active = (count_q == '0) & pending_q & ~redirect_valid_i;
`else
  assign bypass_active = 1'b0;
`endif

  assign buf_valid   = (count_q != '0) & ~redirect_valid_i;
  assign out_valid_o = buf_valid | bypass_active;
  assign out_instr_o = bypass_active ? rom_instr_i    : instr_mem_q[rd_ptr_q];
  assign out_addr_o  = bypass_active ? pending_addr_q : addr_mem_q[rd_ptr_q];
  assign count_o     = count_q;

  assign pop     = out_valid_o & out_ready_i & ~redirect_valid_i;
  // A bypassed word is popped straight off the ROM bus, so the buffer is untouched.
  assign pop_buf = pop & ~bypass_active;
  assign push    = pending_q & ~redirect_valid_i & ~(bypass_active & out_ready_i);

  // Entries that will be occupied once the in-flight word lands; never negative
  // because a pop needs either a buffered entry or a pending bypass word.
  assign occupancy = {1'b0, count_q} + (CntW+1)'(pending_q) - (CntW+1)'(pop);
  assign issue     = redirect_valid_i | (occupancy < (CntW+1)'(DEPTH));

  assign rom_addr_o = redirect_valid_i ? redirect_addr_i : fetch_pc_q;

  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    pending_d      = 1'b0;
    pending_addr_d = pending_addr_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;

    if (issue) begin
      fetch_pc_d     = rom_addr_o + ADDR_W'(1);
      pending_d      = 1'b1;
      pending_addr_d = rom_addr_o;
    end

    if (redirect_valid_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop_buf) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop_buf);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q     <= RESET_ADDR;
      pending_q      <= 1'b0;
      pending_addr_q <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      pending_q      <= pending_d;
      pending_addr_q <= pending_addr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
    end
  end

  // Storage is reset so the head reads as zero until the first word lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        addr_mem_q[i]  <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= rom_instr_i;
      addr_mem_q[wr_ptr_q]  <= pending_addr_q;
    end
  end

endmodule
